// File: rtl/mux_4_1_rr_arbiter.sv
// mux_4_1_rr_arbiter
//   Round-robin arbiter in front of a shared 4:1 data mux. Each cycle one
//   valid requester is granted, starting the search at the rotating pointer.
//   Its word is steered through the mux into a single-entry output register.
//   The output register reloads back-to-back while the consumer keeps
//   out_ready high, giving one word per cycle.
//
// Ports
//   clk        in   1    clock, all state updates on posedge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   4    requester i offers in_data[i]
//   in_data    in   4*W  packed, requester i at [i*W +: W]
//   in_ready   out  4    one-hot (or zero): requester accepted this cycle
//   out_valid  out  1    output register holds a word
//   out_data   out  W    held word (keeps last value when invalid)
//   out_src    out  2    requester index that produced out_data
//   out_ready  in   1    consumer takes out_data this cycle

module mux_4_1_rr_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_src,
    input  logic           out_ready
);

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

    state_e         state_q;
    logic [1:0]     ptr_q;
    logic [W-1:0]   data_q;
    logic [1:0]     src_q;

    logic [1:0]     grant;
    logic           grant_valid;
    logic [W-1:0]   mux_data;
    logic           can_load;
    logic           accept;

    // Rotating priority search. Walking from the lowest-priority offset down
    // to offset 0 lets the last hit (highest priority) win. The index sum is
    // two bits wide, so ptr+k wraps modulo 4 on its own.
    always_comb begin
        grant       = ptr_q;
        grant_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr_q + 2'(k)]) begin
                grant       = ptr_q + 2'(k);
                grant_valid = 1'b1;
            end
        end
    end

    // Shared 4:1 data mux, selected by the grant.
    always_comb begin
        mux_data = '0;
        unique case (grant)
            2'd0: mux_data = in_data[0*W +: W];
            2'd1: mux_data = in_data[1*W +: W];
            2'd2: mux_data = in_data[2*W +: W];
            2'd3: mux_data = in_data[3*W +: W];
            default: mux_data = '0;
        endcase
    end

    // The slot can take a word if it is empty or being drained this cycle.
    assign can_load = (state_q == StEmpty) || out_ready;
    assign accept   = can_load && grant_valid;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output slot FSM; data, source and pointer only move on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            ptr_q   <= 2'd0;
            data_q  <= '0;
            src_q   <= 2'd0;
        end else begin
            if (accept) begin
                data_q <= mux_data;
                src_q  <= grant;
                ptr_q  <= grant + 2'd1;
            end
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    // accept here implies out_ready, so a reload stays FULL.
                    if (out_ready && !accept) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb_mux_4_1_rr_arbiter
//   Scoreboard bench: every word the model expects to be accepted is pushed
//   as {src, data}; each drain observed at the DUT output pops and compares.

module tb_mux_4_1_rr_arbiter;

    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [3:0]     in_valid = '0;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic           m_valid;
    logic [1:0]     m_ptr;
    logic [5:0]     sb[$];
    int             wait_cnt[4];

    mux_4_1_rr_arbiter #(
        .W(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {found, index} of the first valid requester from p upward.
    function automatic logic [2:0] model_grant(input logic [1:0] p, input logic [3:0] v);
        logic [1:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (v[idx]) return {1'b1, idx};
        end
        return 3'b000;
    endfunction

    // Called at a negedge; leaves with rst_n released at a later negedge.
    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs and the
    // registered state, update the model, advance to the next negedge.
    task automatic cycle(input logic [3:0] v, input logic [4*W-1:0] d, input logic r);
        logic [2:0] g;
        logic       acc;
        logic [3:0] exp_ready;
        logic [5:0] exp_word;
        logic [1:0] obs;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        g         = model_grant(m_ptr, v);
        acc       = g[2] && (!m_valid || r);
        exp_ready = acc ? (4'b0001 << g[1:0]) : 4'b0000;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (m_valid && r) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                check("out_word", 32'({out_src, out_data}), 32'(exp_word));
            end
        end
        // Fairness, measured on the grant the DUT actually gives.
        if (in_ready != 4'b0000) begin
            obs = 2'd0;
            for (int i = 0; i < 4; i++) if (in_ready[i]) obs = 2'(i);
            check("fair_wait_le3", 32'(wait_cnt[obs] <= 3), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (!v[i] || i == int'(obs)) wait_cnt[i] = 0;
                else wait_cnt[i]++;
            end
        end else begin
            for (int i = 0; i < 4; i++) if (!v[i]) wait_cnt[i] = 0;
        end
        if (acc) begin
            sb.push_back({g[1:0], d[g[1:0]*W +: W]});
            m_valid = 1'b1;
            m_ptr   = g[1:0] + 2'd1;
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    logic [1:0] seq_src [5];
    logic [3:0] rv;

    initial begin
        seq_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        @(negedge clk);

        // All requesters valid: round-robin 0,1,2,3,0.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 16'h4321 + 16'(i * 16'h1111), 1'b1);
            check("seq_src", 32'(out_src), 32'(seq_src[i]));
        end

        // Lone requester 2 with 4'hA; pointer then sits at 3.
        apply_reset();
        cycle(4'b0100, 16'h0A00, 1'b1);
        check("single_data", 32'(out_data), 32'hA);
        check("single_src", 32'(out_src), 32'd2);
        cycle(4'b1111, 16'h9876, 1'b1);
        check("after_ptr3_src", 32'(out_src), 32'd3);

        // Stall with 4'h5 held, then back-to-back reload on release.
        apply_reset();
        cycle(4'b0001, 16'h0005, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 16'hBCDE, 1'b0);
            check("stall_data", 32'(out_data), 32'h5);
        end
        cycle(4'b1111, 16'hBCDE, 1'b1);
        check("reload_valid", 32'(out_valid), 32'd1);
        check("reload_src", 32'(out_src), 32'd1);

        // Pointer wrap: ptr=3, only 0 and 1 valid.
        apply_reset();
        cycle(4'b0100, 16'h0300, 1'b1);
        cycle(4'b0011, 16'h0021, 1'b1);
        check("wrap_src0", 32'(out_src), 32'd0);
        cycle(4'b0011, 16'h0043, 1'b1);
        check("wrap_src1", 32'(out_src), 32'd1);

        // Mid-stream reset while FULL, then first grant is 0.
        cycle(4'b1111, 16'h7777, 1'b0);
        apply_reset();
        cycle(4'b1111, 16'h1234, 1'b1);
        check("post_rst_src", 32'(out_src), 32'd0);

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            rv = 4'($urandom);
            cycle(rv, 16'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int n = 0; n < 3; n++) cycle(4'b0000, 16'h0000, 1'b1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
